// File: rtl/rvfi_consistency_monitor.sv
// RVFI retirement consistency monitor: order, PC continuity, x0, shadow read-back and mask legality checks.
// Latency: err_* and retire_count update one cycle after the sampled retirement; no backpressure, every rvfi_valid is consumed.
// Optional shadow register file with RS1/RS2 read-back checks is built when RVFI_MON_SHADOW_EN is defined.
module rvfi_consistency_monitor #(
    parameter bit          STOP_ON_ERROR  = 1'b1,
    parameter bit          CHECK_RESET_PC = 1'b0,
    parameter logic [31:0] RESET_PC       = 32'h8000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        rvfi_valid,
    input  logic [63:0] rvfi_order,
    input  logic        rvfi_trap,
    input  logic        rvfi_halt,
    input  logic        rvfi_intr,
    input  logic [4:0]  rvfi_rs1_addr,
    input  logic [4:0]  rvfi_rs2_addr,
    input  logic [31:0] rvfi_rs1_rdata,
    input  logic [31:0] rvfi_rs2_rdata,
    input  logic [4:0]  rvfi_rd_addr,
    input  logic [31:0] rvfi_rd_wdata,
    input  logic [31:0] rvfi_pc_rdata,
    input  logic [31:0] rvfi_pc_wdata,
    input  logic [31:0] rvfi_mem_addr,
    input  logic [3:0]  rvfi_mem_rmask,
    input  logic [3:0]  rvfi_mem_wmask,
    output logic [63:0] retire_count,
    output logic        err_valid,
    output logic [2:0]  err_code,
    output logic [63:0] err_order,
    output logic [31:0] err_pc,
    output logic        err_flag,
    output logic        halted
);

    typedef enum logic [1:0] {
        WAIT_FIRST = 2'd0,
        RUN        = 2'd1,
        HALTED     = 2'd2,
        FAILED     = 2'd3
    } state_t;

    localparam logic [2:0] ERR_NONE       = 3'd0;
    localparam logic [2:0] ERR_ORDER      = 3'd1;
    localparam logic [2:0] ERR_PC         = 3'd2;
    localparam logic [2:0] ERR_X0         = 3'd3;
    localparam logic [2:0] ERR_RS1        = 3'd4;
    localparam logic [2:0] ERR_RS2        = 3'd5;
    localparam logic [2:0] ERR_MASK       = 3'd6;
    localparam logic [2:0] ERR_AFTER_HALT = 3'd7;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] prev_order;
    logic [31:0] prev_pc_wdata;

    logic        active;
    logic        first;
    logic        in_run;
    logic        in_halted;

    logic        ord_bad;
    logic        pc_bad;
    logic        x0_bad;
    logic        rs1_bad;
    logic        rs2_bad;
    logic        mask_bad;
    logic [2:0]  err_code_sel;
    logic        err_hit;

    function automatic logic mask_legal(input logic [3:0] mask, input logic [1:0] lsb);
        case (mask)
            4'h0, 4'h1, 4'h2, 4'h4, 4'h8: mask_legal = 1'b1;
            4'h3:                         mask_legal = ~lsb[0];
            4'hC:                         mask_legal = (lsb == 2'd2);
            4'hF:                         mask_legal = (lsb == 2'd0);
            default:                      mask_legal = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= WAIT_FIRST;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            WAIT_FIRST: if (rvfi_valid) state_nxt = rvfi_halt ? HALTED : RUN;
            RUN:        if (rvfi_valid && rvfi_halt) state_nxt = HALTED;
            default:    state_nxt = state;
        endcase
        if (STOP_ON_ERROR && err_hit) begin
            state_nxt = FAILED;
        end
    end

    // FAILED decodes to no activity, which freezes every counter and register below.
    always_comb begin
        active    = 1'b0;
        first     = 1'b0;
        in_run    = 1'b0;
        in_halted = 1'b0;
        case (state)
            WAIT_FIRST: begin
                active = rvfi_valid;
                first  = 1'b1;
            end
            RUN: begin
                active = rvfi_valid;
                in_run = 1'b1;
            end
            HALTED: begin
                active    = rvfi_valid;
                in_halted = 1'b1;
            end
            default: active = 1'b0;
        endcase
    end

    always_comb begin
        ord_bad  = first ? (rvfi_order != 64'd0) : (rvfi_order != prev_order + 64'd1);
        pc_bad   = (in_run && !rvfi_intr && (rvfi_pc_rdata != prev_pc_wdata)) ||
                   (CHECK_RESET_PC && first && (rvfi_pc_rdata != RESET_PC));
        x0_bad   = ((rvfi_rd_addr  == 5'd0) && (rvfi_rd_wdata  != 32'd0)) ||
                   ((rvfi_rs1_addr == 5'd0) && (rvfi_rs1_rdata != 32'd0)) ||
                   ((rvfi_rs2_addr == 5'd0) && (rvfi_rs2_rdata != 32'd0));
        mask_bad = !mask_legal(rvfi_mem_rmask, rvfi_mem_addr[1:0]) ||
                   !mask_legal(rvfi_mem_wmask, rvfi_mem_addr[1:0]);
    end

    // Lowest code wins when one retirement breaks several rules.
    always_comb begin
        err_code_sel = ERR_NONE;
        if (ord_bad)        err_code_sel = ERR_ORDER;
        else if (pc_bad)    err_code_sel = ERR_PC;
        else if (x0_bad)    err_code_sel = ERR_X0;
        else if (rs1_bad)   err_code_sel = ERR_RS1;
        else if (rs2_bad)   err_code_sel = ERR_RS2;
        else if (mask_bad)  err_code_sel = ERR_MASK;
        else if (in_halted) err_code_sel = ERR_AFTER_HALT;
    end

    assign err_hit = active && (err_code_sel != ERR_NONE);

`ifdef RVFI_MON_SHADOW_EN
    logic [31:0] shadow [1:31];
    logic [31:1] shadow_vld;
    logic        rs1_live;
    logic        rs2_live;
    logic        rs1_adopt;
    logic        rs2_adopt;
    logic        rd_wr;

    assign rs1_live  = (rvfi_rs1_addr != 5'd0);
    assign rs2_live  = (rvfi_rs2_addr != 5'd0);
    assign rs1_bad   = rs1_live && shadow_vld[rvfi_rs1_addr] && (shadow[rvfi_rs1_addr] != rvfi_rs1_rdata);
    assign rs2_bad   = rs2_live && shadow_vld[rvfi_rs2_addr] && (shadow[rvfi_rs2_addr] != rvfi_rs2_rdata);
    assign rs1_adopt = active && rs1_live && !shadow_vld[rvfi_rs1_addr];
    assign rs2_adopt = active && rs2_live && !shadow_vld[rvfi_rs2_addr];
    assign rd_wr     = active && !rvfi_trap && (rvfi_rd_addr != 5'd0);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_vld <= '0;
        end else begin
            if (rs1_adopt) shadow_vld[rvfi_rs1_addr] <= 1'b1;
            if (rs2_adopt) shadow_vld[rvfi_rs2_addr] <= 1'b1;
            if (rd_wr)     shadow_vld[rvfi_rd_addr]  <= 1'b1;
        end
    end

    // Later writes take precedence: the retiring rd value is the newest architectural state.
    always_ff @(posedge clock) begin
        if (rs1_adopt) shadow[rvfi_rs1_addr] <= rvfi_rs1_rdata;
        if (rs2_adopt) shadow[rvfi_rs2_addr] <= rvfi_rs2_rdata;
        if (rd_wr)     shadow[rvfi_rd_addr]  <= rvfi_rd_wdata;
    end
`else
    assign rs1_bad = 1'b0;
    assign rs2_bad = 1'b0;
`endif

    logic unused_bits;
    assign unused_bits = ^{rvfi_trap, rvfi_mem_addr[31:2]};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retire_count  <= 64'd0;
            err_valid     <= 1'b0;
            err_code      <= 3'd0;
            err_order     <= 64'd0;
            err_pc        <= 32'd0;
            err_flag      <= 1'b0;
            halted        <= 1'b0;
            prev_order    <= 64'd0;
            prev_pc_wdata <= 32'd0;
        end else begin
            err_valid <= err_hit;
            if (active) begin
                retire_count  <= retire_count + 64'd1;
                prev_order    <= rvfi_order;
                prev_pc_wdata <= rvfi_pc_wdata;
                if (rvfi_halt) begin
                    halted <= 1'b1;
                end
            end
            if (err_hit) begin
                err_code  <= err_code_sel;
                err_order <= rvfi_order;
                err_pc    <= rvfi_pc_rdata;
                err_flag  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rvfi_consistency_monitor.sv
// Randomized bench for rvfi_consistency_monitor: two instances (stop-on-error, and continue with reset-PC check)
// checked every cycle against a behavioural model of the retirement rules.
module tb_rvfi_consistency_monitor;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        rvfi_valid;
    logic [63:0] rvfi_order;
    logic        rvfi_trap, rvfi_halt, rvfi_intr;
    logic [4:0]  rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rd_addr;
    logic [31:0] rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_rd_wdata;
    logic [31:0] rvfi_pc_rdata, rvfi_pc_wdata, rvfi_mem_addr;
    logic [3:0]  rvfi_mem_rmask, rvfi_mem_wmask;

    logic [63:0] rc [2];
    logic        ev [2];
    logic [2:0]  ec [2];
    logic [63:0] eo [2];
    logic [31:0] ep [2];
    logic        ef [2];
    logic        hl [2];

    always #5 clock = ~clock;

    rvfi_consistency_monitor #(.STOP_ON_ERROR(1'b1), .CHECK_RESET_PC(1'b0)) u_stop (
        .clock(clock), .reset(reset), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .retire_count(rc[0]), .err_valid(ev[0]), .err_code(ec[0]), .err_order(eo[0]),
        .err_pc(ep[0]), .err_flag(ef[0]), .halted(hl[0])
    );

    rvfi_consistency_monitor #(.STOP_ON_ERROR(1'b0), .CHECK_RESET_PC(1'b1)) u_cont (
        .clock(clock), .reset(reset), .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_trap(rvfi_trap), .rvfi_halt(rvfi_halt), .rvfi_intr(rvfi_intr),
        .rvfi_rs1_addr(rvfi_rs1_addr), .rvfi_rs2_addr(rvfi_rs2_addr),
        .rvfi_rs1_rdata(rvfi_rs1_rdata), .rvfi_rs2_rdata(rvfi_rs2_rdata),
        .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .rvfi_mem_addr(rvfi_mem_addr), .rvfi_mem_rmask(rvfi_mem_rmask), .rvfi_mem_wmask(rvfi_mem_wmask),
        .retire_count(rc[1]), .err_valid(ev[1]), .err_code(ec[1]), .err_order(eo[1]),
        .err_pc(ep[1]), .err_flag(ef[1]), .halted(hl[1])
    );

    int n_total;
    int n_bad;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h @%0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural model; instance 0 stops on error, instance 1 checks the reset PC.
    localparam int PH_WAIT = 0, PH_RUN = 1, PH_HALT = 2, PH_DEAD = 3;
    int          m_phase [2];
    logic [63:0] m_prev_ord [2];
    logic [31:0] m_prev_pc [2];
    logic [63:0] m_cnt [2];
    logic        m_flag [2], m_halted [2], m_ev [2];
    logic [2:0]  m_code [2];
    logic [63:0] m_eo [2];
    logic [31:0] m_ep [2];
    logic [31:0] m_reg [2][32];
    bit          m_known [2][32];

    function automatic bit mask_ok(input logic [3:0] m, input logic [31:0] a);
        case (m)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd8: return 1'b1;
            4'd3:  return (a % 2) == 0;
            4'd12: return (a % 4) == 2;
            4'd15: return (a % 4) == 0;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_phase[k] = PH_WAIT; m_prev_ord[k] = 0; m_prev_pc[k] = 0; m_cnt[k] = 0;
            m_flag[k] = 0; m_halted[k] = 0; m_ev[k] = 0; m_code[k] = 0; m_eo[k] = 0; m_ep[k] = 0;
            for (int r = 0; r < 32; r++) begin
                m_known[k][r] = 0;
                m_reg[k][r] = 0;
            end
        end
    endtask

    task automatic model_step(input int k);
        int code;
        bit first, a1, a2;
        m_ev[k] = 0;
        if (!rvfi_valid || m_phase[k] == PH_DEAD) return;
        first = (m_phase[k] == PH_WAIT);
        code = 0;
        if (first ? (rvfi_order != 0) : (rvfi_order != m_prev_ord[k] + 64'd1)) code = 1;
        else if (m_phase[k] == PH_RUN && !rvfi_intr && rvfi_pc_rdata != m_prev_pc[k]) code = 2;
        else if (first && k == 1 && rvfi_pc_rdata != 32'h8000_0000) code = 2;
        else if ((rvfi_rd_addr == 0 && rvfi_rd_wdata != 0) || (rvfi_rs1_addr == 0 && rvfi_rs1_rdata != 0) ||
                 (rvfi_rs2_addr == 0 && rvfi_rs2_rdata != 0)) code = 3;
`ifdef RVFI_MON_SHADOW_EN
        else if (rvfi_rs1_addr != 0 && m_known[k][rvfi_rs1_addr] && m_reg[k][rvfi_rs1_addr] != rvfi_rs1_rdata) code = 4;
        else if (rvfi_rs2_addr != 0 && m_known[k][rvfi_rs2_addr] && m_reg[k][rvfi_rs2_addr] != rvfi_rs2_rdata) code = 5;
`endif
        else if (!mask_ok(rvfi_mem_rmask, rvfi_mem_addr) || !mask_ok(rvfi_mem_wmask, rvfi_mem_addr)) code = 6;
        else if (m_phase[k] == PH_HALT) code = 7;

        m_cnt[k] = m_cnt[k] + 1;
        if (code != 0) begin
            m_ev[k] = 1; m_code[k] = code[2:0]; m_eo[k] = rvfi_order; m_ep[k] = rvfi_pc_rdata; m_flag[k] = 1;
        end
        if (rvfi_halt) m_halted[k] = 1;
        if (m_phase[k] != PH_HALT) m_phase[k] = rvfi_halt ? PH_HALT : PH_RUN;
        if (code != 0 && k == 0) m_phase[k] = PH_DEAD;
        m_prev_ord[k] = rvfi_order;
        m_prev_pc[k] = rvfi_pc_wdata;
`ifdef RVFI_MON_SHADOW_EN
        a1 = rvfi_rs1_addr != 0 && !m_known[k][rvfi_rs1_addr];
        a2 = rvfi_rs2_addr != 0 && !m_known[k][rvfi_rs2_addr];
        if (a1) begin m_known[k][rvfi_rs1_addr] = 1; m_reg[k][rvfi_rs1_addr] = rvfi_rs1_rdata; end
        if (a2) begin m_known[k][rvfi_rs2_addr] = 1; m_reg[k][rvfi_rs2_addr] = rvfi_rs2_rdata; end
        if (!rvfi_trap && rvfi_rd_addr != 0) begin
            m_known[k][rvfi_rd_addr] = 1; m_reg[k][rvfi_rd_addr] = rvfi_rd_wdata;
        end
`else
        a1 = 0; a2 = 0;
`endif
    endtask

    task automatic compare(input int k);
        chk($sformatf("u%0d err_valid", k), ev[k], m_ev[k]);
        chk($sformatf("u%0d err_code", k), ec[k], m_code[k]);
        chk($sformatf("u%0d err_order", k), eo[k], m_eo[k]);
        chk($sformatf("u%0d err_pc", k), ep[k], m_ep[k]);
        chk($sformatf("u%0d retire_count", k), rc[k], m_cnt[k]);
        chk($sformatf("u%0d err_flag", k), ef[k], m_flag[k]);
        chk($sformatf("u%0d halted", k), hl[k], m_halted[k]);
    endtask

    // Called at a negedge with inputs already driven.
    task automatic step();
        for (int k = 0; k < 2; k++) model_step(k);
        @(posedge clock);
        #1;
        for (int k = 0; k < 2; k++) compare(k);
        @(negedge clock);
    endtask

    task automatic do_reset();
        rvfi_valid = 0;
        #2 reset = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) compare(k);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic set_ret(input logic [63:0] ord, input logic [31:0] pc);
        rvfi_valid = 1; rvfi_order = ord; rvfi_trap = 0; rvfi_halt = 0; rvfi_intr = 0;
        rvfi_rs1_addr = 0; rvfi_rs2_addr = 0; rvfi_rs1_rdata = 0; rvfi_rs2_rdata = 0;
        rvfi_rd_addr = 0; rvfi_rd_wdata = 0; rvfi_pc_rdata = pc; rvfi_pc_wdata = pc + 32'd4;
        rvfi_mem_addr = 0; rvfi_mem_rmask = 0; rvfi_mem_wmask = 0;
    endtask

    // Random generator keeps a legal architectural stream; faults are injected on top.
    logic [63:0] g_ord;
    logic [31:0] g_pc;
    logic [31:0] g_reg [32];

    task automatic gen_reset();
        g_ord = 0;
        g_pc = 32'h8000_0000;
        g_reg[0] = 0;
        for (int r = 1; r < 32; r++) g_reg[r] = $urandom;
    endtask

    task automatic gen_legal();
        logic [31:0] base;
        logic [3:0] m;
        set_ret(g_ord, g_pc);
        rvfi_trap = ($urandom_range(0, 15) == 0);
        rvfi_halt = ($urandom_range(0, 99) == 0);
        rvfi_rs1_addr = 5'($urandom); rvfi_rs2_addr = 5'($urandom); rvfi_rd_addr = 5'($urandom);
        rvfi_rs1_rdata = g_reg[rvfi_rs1_addr];
        rvfi_rs2_rdata = g_reg[rvfi_rs2_addr];
        rvfi_rd_wdata = (rvfi_rd_addr == 0) ? 32'd0 : $urandom;
        if ($urandom_range(0, 9) == 0) begin
            rvfi_intr = 1;
            rvfi_pc_rdata = $urandom & 32'hFFFF_FFFC;
        end
        rvfi_pc_wdata = ($urandom_range(0, 5) == 0) ? ($urandom & 32'hFFFF_FFFC) : rvfi_pc_rdata + 32'd4;
        base = $urandom & 32'hFFFF_FFFC;
        case ($urandom_range(0, 7))
            0: begin m = 4'h0; rvfi_mem_addr = $urandom; end
            1: begin m = 4'h1 << $urandom_range(0, 3); rvfi_mem_addr = base + $urandom_range(0, 3); end
            2: begin m = 4'h3; rvfi_mem_addr = base + 2 * $urandom_range(0, 1); end
            3: begin m = 4'hC; rvfi_mem_addr = base + 2; end
            4: begin m = 4'hF; rvfi_mem_addr = base; end
            default: begin m = 4'h0; rvfi_mem_addr = base; end
        endcase
        if ($urandom_range(0, 1) == 0) rvfi_mem_rmask = m; else rvfi_mem_wmask = m;
    endtask

    task automatic inject();
        case ($urandom_range(0, 6))
            0: rvfi_order = rvfi_order + 64'd2;
            1: begin rvfi_intr = 0; rvfi_pc_rdata = rvfi_pc_rdata ^ 32'h4; end
            2: begin rvfi_rd_addr = 0; rvfi_rd_wdata = $urandom | 32'h1; end
            3: rvfi_rs1_rdata = rvfi_rs1_rdata ^ (32'h1 << $urandom_range(0, 31));
            4: rvfi_rs2_rdata = rvfi_rs2_rdata ^ (32'h1 << $urandom_range(0, 31));
            5: rvfi_mem_wmask = 4'h5;
            default: begin rvfi_mem_rmask = 4'hF; rvfi_mem_addr = ($urandom & 32'hFFFF_FFFC) + 1; end
        endcase
    endtask

    task automatic gen_commit();
        g_ord = rvfi_order + 64'd1;
        g_pc = rvfi_pc_wdata;
        if (!rvfi_trap && rvfi_rd_addr != 0) g_reg[rvfi_rd_addr] = rvfi_rd_wdata;
    endtask

    initial begin
        n_total = 0;
        n_bad = 0;
        set_ret(0, 0);
        rvfi_valid = 0;
        model_reset();
        @(negedge clock);
        for (int k = 0; k < 2; k++) compare(k);
        reset = 1'b0;

        // Clean stream of three retirements.
        for (int i = 0; i < 3; i++) begin
            set_ret(i, 32'h8000_0000 + 4 * i);
            step();
        end
        rvfi_valid = 0;
        step();
        chk("clean count", rc[0], 64'd3);
        chk("clean flag", ef[0], 1'b0);

        // Order gap 0,1,3 then more retirements on the stopping instance.
        do_reset();
        set_ret(0, 32'h8000_0000); step();
        set_ret(1, 32'h8000_0004); step();
        set_ret(3, 32'h8000_0008); step();
        chk("gap valid", ev[0], 1'b1);
        chk("gap code", ec[0], 3'd1);
        chk("gap order", eo[0], 64'd3);
        set_ret(4, 32'h8000_000C); step();
        set_ret(5, 32'h8000_0010); step();
        chk("gap frozen count", rc[0], 64'd3);

        // Shadow read-back mismatch.
        do_reset();
        set_ret(0, 32'h8000_0000); rvfi_rd_addr = 5; rvfi_rd_wdata = 32'hDEAD_BEEF; step();
        set_ret(1, 32'h8000_0004); rvfi_rs1_addr = 5; rvfi_rs1_rdata = 32'h1234; step();
`ifdef RVFI_MON_SHADOW_EN
        chk("rs1 code", ec[1], 3'd4);
`else
        chk("rs1 no error", ev[1], 1'b0);
`endif

        // x0 write outranks a misaligned mask.
        do_reset();
        set_ret(0, 32'h8000_0000); rvfi_rd_wdata = 1; rvfi_mem_wmask = 4'h3; rvfi_mem_addr = 32'h1001; step();
        chk("x0 code", ec[0], 3'd3);

        // Halt on order 4, then one more retirement.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set_ret(i, 32'h8000_0000 + 4 * i);
            rvfi_halt = (i == 4);
            step();
        end
        chk("halt flag", hl[1], 1'b1);
        chk("after halt code", ec[1], 3'd7);
        chk("after halt order", eo[1], 64'd5);

        // Asynchronous reset out of FAILED, then a clean restart.
        do_reset();
        set_ret(0, 32'h8000_0000); step();
        chk("restart count", rc[0], 64'd1);
        chk("restart clean", ev[0], 1'b0);

        // Random epochs, each ending in an asynchronous reset.
        for (int e = 0; e < 30; e++) begin
            do_reset();
            gen_reset();
            for (int c = 0; c < 200; c++) begin
                if ($urandom_range(0, 4) == 0) begin
                    set_ret($urandom, $urandom);
                    rvfi_valid = 0;
                    step();
                end else begin
                    gen_legal();
                    if ($urandom_range(0, 11) == 0) inject();
                    step();
                    gen_commit();
                end
            end
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
